// File: rtl/vtmon_pkg.sv
// vtmon_pkg: shared state encodings and widths for the video timing monitor
package vtmon_pkg;
    typedef enum logic [1:0] {ST_WAIT_VS, ST_MEASURE, ST_LOCKED} state_e;
    localparam int ERR_W = 16;
endpackage

// File: rtl/vtmon_pixchk.sv
// vtmon_pixchk: checks that valid pixels are grey and step by one per pixel, counting mismatches
module vtmon_pixchk
    import vtmon_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic [3*PW-1:0]  rgb_i,
    input  logic             err_clr_i,
    output logic             pix_err_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    logic [PW-1:0]    r, g, b, ref_q;
    logic             seeded_q, pix_err_q, err;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    assign {r, g, b} = rgb_i;
    assign err = vld_i && (r != g || g != b || (seeded_q && r != ref_q + PW'(1)));
    assign err_cnt_d = err_clr_i ? ERR_W'(err) :
                       err && !(&err_cnt_q) ? err_cnt_q + ERR_W'(1) : err_cnt_q;

    // reference always follows the received r so a ramp jump costs one error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded_q  <= 1'b0;
            ref_q     <= '0;
            pix_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            pix_err_q <= err;
            err_cnt_q <= err_cnt_d;
            if (vld_i) begin
                seeded_q <= 1'b1;
                ref_q    <= r;
            end
        end
    end

    assign pix_err_o = pix_err_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: rtl/vtmon.sv
// vtmon: video timing monitor recovering frame geometry and checking the ramp pixel pattern
module vtmon
    import vtmon_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int PW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              rgb_vld,
    input  logic [3*PW-1:0]   rgb,
    input  logic              err_clr,
    output logic [H_BITS-1:0] h_total,
    output logic [H_BITS-1:0] hs_width,
    output logic [H_BITS-1:0] hact_start,
    output logic [H_BITS-1:0] hact_len,
    output logic [V_BITS-1:0] v_total,
    output logic [V_BITS-1:0] vs_width,
    output logic [V_BITS-1:0] vact_lines,
    output logic              meas_vld,
    output logic              locked,
    output logic              pix_err,
    output logic [ERR_W-1:0]  err_cnt
);
    logic              hs_q, vs_q, vld_q, hs_p_q, vs_p_q, vld_p_q;
    logic [3*PW-1:0]   rgb_q;
    logic              hs_rise, hs_fall, vs_rise, vs_fall, vld_rise;
    logic [H_BITS-1:0] h_cnt_q, vld_cnt_q, hst_w_q, hsw_w_q, ht_w_q, fhst_q, fhln_q;
    logic [V_BITS-1:0] v_cnt_q, vsw_w_q, vact_q;
    logic              act_q;
    logic [H_BITS-1:0] ht_c, fhst_c, fhln_c;
    logic [V_BITS-1:0] vcnt_c, vact_c;
    logic [H_BITS-1:0] h_total_q, hs_width_q, hact_start_q, hact_len_q;
    logic [V_BITS-1:0] v_total_q, vs_width_q, vact_lines_q;
    logic              meas_vld_q, same, pub;
    state_e            state_q, state_d;

    function automatic logic [H_BITS-1:0] h_inc(input logic [H_BITS-1:0] x);
        return &x ? x : x + H_BITS'(1);
    endfunction

    function automatic logic [V_BITS-1:0] v_inc(input logic [V_BITS-1:0] x);
        return &x ? x : x + V_BITS'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hs_q, vs_q, vld_q, hs_p_q, vs_p_q, vld_p_q} <= '0;
            rgb_q <= '0;
        end else begin
            {hs_q, vs_q, vld_q}       <= {hs, vs, rgb_vld};
            {hs_p_q, vs_p_q, vld_p_q} <= {hs_q, vs_q, vld_q};
            rgb_q <= rgb;
        end
    end

    assign hs_rise  = hs_q & ~hs_p_q;
    assign hs_fall  = ~hs_q & hs_p_q;
    assign vs_rise  = vs_q & ~vs_p_q;
    assign vs_fall  = ~vs_q & vs_p_q;
    assign vld_rise = vld_q & ~vld_p_q;

    // values as they stand once the current line is closed, so a frame edge
    // coinciding with a line edge publishes the finished line
    assign ht_c   = hs_rise ? h_inc(h_cnt_q) : ht_w_q;
    assign fhst_c = hs_rise && act_q ? hst_w_q : fhst_q;
    assign fhln_c = hs_rise && act_q ? vld_cnt_q : fhln_q;
    assign vcnt_c = hs_rise ? v_inc(v_cnt_q) : v_cnt_q;
    assign vact_c = hs_rise && act_q ? v_inc(vact_q) : vact_q;
    assign same   = {ht_c, hsw_w_q, fhst_c, fhln_c, vcnt_c, vsw_w_q, vact_c} ==
                    {h_total_q, hs_width_q, hact_start_q, hact_len_q, v_total_q, vs_width_q, vact_lines_q};

    always_comb begin
        pub     = vs_rise && state_q != ST_WAIT_VS;
        state_d = state_q;
        if (vs_rise)
            state_d = state_q == ST_WAIT_VS || !same ? ST_MEASURE : ST_LOCKED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            vld_cnt_q <= '0;
            hst_w_q   <= '0;
            hsw_w_q   <= '0;
            act_q     <= 1'b0;
        end else begin
            h_cnt_q   <= hs_rise ? '0 : h_inc(h_cnt_q);
            vld_cnt_q <= hs_rise ? '0 : vld_q ? h_inc(vld_cnt_q) : vld_cnt_q;
            act_q     <= !hs_rise && (act_q || vld_q);
            if (vld_rise && !act_q)
                hst_w_q <= h_inc(h_cnt_q);
            if (hs_fall)
                hsw_w_q <= h_inc(h_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ht_w_q  <= '0;
            fhst_q  <= '0;
            fhln_q  <= '0;
            v_cnt_q <= '0;
            vact_q  <= '0;
            vsw_w_q <= '0;
        end else begin
            ht_w_q  <= ht_c;
            fhst_q  <= fhst_c;
            fhln_q  <= fhln_c;
            v_cnt_q <= vs_rise ? '0 : vcnt_c;
            vact_q  <= vs_rise ? '0 : vact_c;
            if (vs_fall)
                vsw_w_q <= vcnt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_VS;
            meas_vld_q   <= 1'b0;
            h_total_q    <= '0;
            hs_width_q   <= '0;
            hact_start_q <= '0;
            hact_len_q   <= '0;
            v_total_q    <= '0;
            vs_width_q   <= '0;
            vact_lines_q <= '0;
        end else begin
            state_q    <= state_d;
            meas_vld_q <= pub;
            if (pub) begin
                h_total_q    <= ht_c;
                hs_width_q   <= hsw_w_q;
                hact_start_q <= fhst_c;
                hact_len_q   <= fhln_c;
                v_total_q    <= vcnt_c;
                vs_width_q   <= vsw_w_q;
                vact_lines_q <= vact_c;
            end
        end
    end

    vtmon_pixchk #(.PW(PW)) u_pixchk (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_i     (vld_q),
        .rgb_i     (rgb_q),
        .err_clr_i (err_clr),
        .pix_err_o (pix_err),
        .err_cnt_o (err_cnt)
    );

    assign h_total    = h_total_q;
    assign hs_width   = hs_width_q;
    assign hact_start = hact_start_q;
    assign hact_len   = hact_len_q;
    assign v_total    = v_total_q;
    assign vs_width   = vs_width_q;
    assign vact_lines = vact_lines_q;
    assign meas_vld   = meas_vld_q;
    assign locked     = state_q == ST_LOCKED;
endmodule

// File: tb/tb_vtmon.sv
// tb_vtmon: scoreboard bench driving ramp video frames into vtmon and checking measurements and pixel errors
module tb_vtmon;
    localparam int HB = 12, VB = 12, PW = 8;
    localparam int HSW = 10, AST = 20, ALN = 64, NL = 20, VSL = 2, NACT = 8, ACT0 = 6;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            hs = 1'b0, vs = 1'b0, rgb_vld = 1'b0, err_clr = 1'b0;
    logic [3*PW-1:0] rgb = '0;
    logic [HB-1:0]   h_total, hs_width, hact_start, hact_len;
    logic [VB-1:0]   v_total, vs_width, vact_lines;
    logic            meas_vld, locked, pix_err;
    logic [15:0]     err_cnt;

    always #5 clk = ~clk;

    vtmon #(.H_BITS(HB), .V_BITS(VB), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb_vld(rgb_vld), .rgb(rgb),
        .err_clr(err_clr), .h_total(h_total), .hs_width(hs_width), .hact_start(hact_start),
        .hact_len(hact_len), .v_total(v_total), .vs_width(vs_width), .vact_lines(vact_lines),
        .meas_vld(meas_vld), .locked(locked), .pix_err(pix_err), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [11:0] ht, hw, hst, hln, vt, vw, va;
        logic        lk;
    } meas_t;

    meas_t      mq[$];
    int         eq[$];
    meas_t      prev, mm;
    int         total = 0, bad = 0;
    bit         seeded, clr_next, clr_pend;
    logic [7:0] prev_r, ramp = 8'd0;
    int         exp_cnt;
    int         e_idx[3], e_kind[3];
    bit         e_clr[3];
    int         n_e = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // scoreboard monitor: pops an expectation whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n && meas_vld) begin
            chk("meas_pending", int'(mq.size() > 0), 1);
            if (mq.size() > 0) begin
                mm = mq.pop_front();
                chk("h_total", int'(h_total), int'(mm.ht));
                chk("hs_width", int'(hs_width), int'(mm.hw));
                chk("hact_start", int'(hact_start), int'(mm.hst));
                chk("hact_len", int'(hact_len), int'(mm.hln));
                chk("v_total", int'(v_total), int'(mm.vt));
                chk("vs_width", int'(vs_width), int'(mm.vw));
                chk("vact_lines", int'(vact_lines), int'(mm.va));
                chk("locked", int'(locked), int'(mm.lk));
            end
        end
        if (rst_n && pix_err) begin
            chk("err_pending", int'(eq.size() > 0), 1);
            if (eq.size() > 0)
                chk("err_cnt", int'(err_cnt), eq.pop_front());
        end
    end

    task automatic cyc(input logic h, input logic v, input logic d, input logic [23:0] p);
        @(negedge clk);
        hs = h; vs = v; rgb_vld = d; rgb = p;
        err_clr = clr_next;
        clr_next = clr_pend;
        clr_pend = 1'b0;
    endtask

    // reference: every valid pixel grey, r steps by one from the previous received r
    task automatic make_pix(input int k, output logic [23:0] p);
        logic [7:0] r, g, b;
        bit e, clr;
        int kind;
        kind = -1;
        clr = 1'b0;
        for (int i = 0; i < n_e; i++)
            if (e_idx[i] == k) begin
                kind = e_kind[i];
                clr = e_clr[i];
            end
        r = kind == 1 ? ramp + 8'd37 : ramp;
        g = kind == 0 ? ~r : r;
        b = kind == 2 ? r ^ 8'h01 : r;
        e = r != g || g != b || (seeded && r != prev_r + 8'd1);
        if (clr) exp_cnt = e ? 1 : 0;
        else if (e && exp_cnt < 65535) exp_cnt++;
        if (e) eq.push_back(exp_cnt);
        seeded = 1'b1;
        prev_r = r;
        ramp = r + 8'd1;
        clr_pend = clr;
        p = {r, g, b};
    endtask

    task automatic push_meas(input int last_len);
        meas_t m;
        m = '0;
        m.ht = 12'(last_len > 4095 ? 4095 : last_len);
        m.hw = 12'(HSW);
        m.hst = 12'(AST);
        m.hln = 12'(ALN);
        m.vt = 12'(NL);
        m.vw = 12'(VSL);
        m.va = 12'(NACT);
        m.lk = m == prev;
        prev = m;
        prev.lk = 1'b0;
        mq.push_back(m);
    endtask

    task automatic send_frame(input int len, input int last_len, input int n_lines, input bit push);
        int k, ll;
        bit a;
        logic [23:0] p;
        k = 0;
        for (int l = 0; l < n_lines; l++) begin
            ll = (l == NL - 1) ? last_len : len;
            for (int c = 0; c < ll; c++) begin
                a = l >= ACT0 && l < ACT0 + NACT && c >= AST && c < AST + ALN;
                p = '0;
                if (a) begin
                    make_pix(k, p);
                    k++;
                end
                cyc(c < HSW, l < VSL, a, p);
            end
        end
        if (push) push_meas(last_len);
    endtask

    task automatic do_reset();
        chk("queues_drained", mq.size() + eq.size(), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        seeded = 1'b0;
        exp_cnt = 0;
        prev = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_h_total", int'(h_total), 0);
        chk("rst_hs_width", int'(hs_width), 0);
        chk("rst_hact_start", int'(hact_start), 0);
        chk("rst_hact_len", int'(hact_len), 0);
        chk("rst_v_total", int'(v_total), 0);
        chk("rst_vs_width", int'(vs_width), 0);
        chk("rst_vact_lines", int'(vact_lines), 0);
        chk("rst_meas_vld", int'(meas_vld), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pix_err", int'(pix_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
    endtask

    initial begin
        clr_next = 1'b0;
        clr_pend = 1'b0;
        ramp = 8'($urandom_range(0, 255));
        do_reset();
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, NL, 1'b1);
        e_idx[0] = $urandom_range(0, 500); e_kind[0] = 0; e_clr[0] = 1'b0; n_e = 1;
        send_frame(100, 100, NL, 1'b1);
        n_e = 0;
        send_frame(100, 100, NL, 1'b1);
        send_frame(101, 101, NL, 1'b1);
        send_frame(101, 101, NL, 1'b1);
        e_idx[0] = 50; e_kind[0] = 0; e_clr[0] = 1'b0;
        e_idx[1] = 60 + $urandom_range(0, 100); e_kind[1] = 1; e_clr[1] = 1'b0;
        e_idx[2] = 300; e_kind[2] = 2; e_clr[2] = 1'b1;
        n_e = 3;
        send_frame(101, 101, NL, 1'b1);
        n_e = 0;
        send_frame(100, 5000, NL, 1'b1);
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, 10, 1'b0);
        do_reset();
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, NL, 1'b1);
        send_frame(100, 100, 1, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0, '0);
        chk("meas_left", mq.size(), 0);
        chk("err_left", eq.size(), 0);
        chk("err_cnt_final", int'(err_cnt), exp_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
